pixel_weight_mac: RTL and testbench

//   Streaming multi-tap multiply-accumulate for the upscaler interpolation datapath.

---
 rtl/pixel_weight_mac.sv | 115 +++++++++++
 tb/tb_pixel_weight_mac.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_weight_mac.sv
// pixel_weight_mac: streaming multi-tap multiply-accumulate for the upscaler
// interpolation datapath. Takes one (unsigned pixel, signed weight) pair per
// cycle, sums TAPS products, then rounds the fixed-point sum and clamps it to
// the pixel range. Two-stage pipeline: multiply (M), then accumulate/output (A).
module pixel_weight_mac #(
  parameter int PIX_W     = 8,
  parameter int WGT_W     = 9,
  parameter int FRAC_BITS = 7,
  parameter int TAPS      = 4,
  parameter int ACC_W     = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        in_pixel,
  input  logic signed [WGT_W-1:0] in_weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIX_W-1:0]        out_pixel,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat
);

  localparam int PROD_W = PIX_W + WGT_W + 1;
  localparam int TAP_W  = $clog2(TAPS);
  localparam int HALF   = 1 << (FRAC_BITS - 1);

  localparam logic [TAP_W-1:0]    LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W + 1)'(HALF);
  localparam logic signed [ACC_W:0] PIX_MAX  = (ACC_W + 1)'((1 << PIX_W) - 1);

  logic                     stall;
  logic                     accept;
  logic [TAP_W-1:0]         tap_idx;
  logic signed [PROD_W-1:0] prod_calc;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;
  logic                     prod_first;
  logic                     prod_last;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    rnd_shift;
  logic [PIX_W-1:0]         clamp_pixel;
  logic                     clamp_sat;

  // A pending result that downstream has not taken freezes the whole pipe.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Zero-extended pixel times signed weight; exact even for the most negative weight.
  assign prod_calc = PROD_W'($signed({1'b0, in_pixel})) * PROD_W'(in_weight);

  // Running sum restarts on the first tap of each group.
  assign prod_ext = ACC_W'(prod);
  assign acc_next = (prod_first ? '0 : acc) + prod_ext;

  // One extra bit keeps the rounding add from wrapping at the accumulator extremes.
  assign rnd_sum   = (ACC_W + 1)'(acc_next) + RND_HALF;
  assign rnd_shift = rnd_sum >>> FRAC_BITS;

  // Clamp the rounded sum into the unsigned pixel range and flag saturation.
  always_comb begin
    clamp_pixel = rnd_shift[PIX_W-1:0];
    clamp_sat   = 1'b0;
    if (rnd_shift < 0) begin
      clamp_pixel = '0;
      clamp_sat   = 1'b1;
    end else if (rnd_shift > PIX_MAX) begin
      clamp_pixel = '1;
      clamp_sat   = 1'b1;
    end
  end

  // Pipeline registers: tap counter, multiply stage, accumulate stage and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_idx    <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_acc    <= '0;
      out_sat    <= 1'b0;
    end else if (!stall) begin
      prod_valid <= accept;
      if (accept) begin
        prod       <= prod_calc;
        prod_first <= (tap_idx == '0);
        prod_last  <= (tap_idx == LAST_TAP);
        tap_idx    <= (tap_idx == LAST_TAP) ? '0 : tap_idx + 1'b1;
      end

      if (prod_valid) begin
        acc <= acc_next;
      end

      if (prod_valid && prod_last) begin
        out_valid <= 1'b1;
        out_acc   <= acc_next;
        out_pixel <= clamp_pixel;
        out_sat   <= clamp_sat;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_weight_mac.sv
// tb_pixel_weight_mac: directed tests for pixel_weight_mac with hand-computed results.
module tb_pixel_weight_mac;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_pixel;
  logic signed [8:0] in_weight;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_pixel;
  logic signed [19:0] out_acc;
  logic              out_sat;

  int checks;
  int passed;

  pixel_weight_mac #(
    .PIX_W(8), .WGT_W(9), .FRAC_BITS(7), .TAPS(4), .ACC_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pixel(in_pixel),
    .in_weight(in_weight),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .out_acc(out_acc),
    .out_sat(out_sat)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one pair for exactly one edge.
  task automatic send_pair(input int p, input int w);
    in_valid  = 1'b1;
    in_pixel  = 8'(p);
    in_weight = 9'(w);
    tick();
  endtask

  // Send a full 4-tap group, then idle one edge so the result is in the output register.
  task automatic feed_group(input int p0, input int p1, input int p2, input int p3,
                            input int w0, input int w1, input int w2, input int w3);
    send_pair(p0, w0);
    send_pair(p1, w1);
    send_pair(p2, w2);
    send_pair(p3, w3);
    in_valid  = 1'b0;
    in_pixel  = '0;
    in_weight = '0;
    tick();
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    in_weight = '0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); else passed++;
    checks++; if (out_pixel !== 8'd0) $display("[TB] FAIL reset_out_pixel: got %0d expected 0", out_pixel); else passed++;
    checks++; if (out_sat !== 1'b0) $display("[TB] FAIL reset_out_sat: got %0b expected 0", out_sat); else passed++;
    checks++; if (out_acc !== 20'sd0) $display("[TB] FAIL reset_out_acc: got %0d expected 0", out_acc); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_identity;
    out_ready = 1'b1;
    send_pair(200, 128);
    send_pair(7, 0);
    send_pair(7, 0);
    send_pair(7, 0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL identity_early_valid: got %0b expected 0", out_valid); else passed++;
    tick();
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL identity_latency: got %0b expected 1", out_valid); else passed++;
    checks++; if (out_pixel !== 8'd200) $display("[TB] FAIL identity_pixel: got %0d expected 200", out_pixel); else passed++;
    checks++; if (out_acc !== 20'sd25600) $display("[TB] FAIL identity_acc: got %0d expected 25600", out_acc); else passed++;
    checks++; if (out_sat !== 1'b0) $display("[TB] FAIL identity_sat: got %0b expected 0", out_sat); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL identity_clear: got %0b expected 0", out_valid); else passed++;
  endtask

  task automatic test_bicubic;
    out_ready = 1'b1;
    feed_group(100, 100, 100, 100, -9, 73, 73, -9);
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bicubic_flat_valid: got %0b expected 1", out_valid); else passed++;
    checks++; if (out_pixel !== 8'd100) $display("[TB] FAIL bicubic_flat_pixel: got %0d expected 100", out_pixel); else passed++;
    checks++; if (out_acc !== 20'sd12800) $display("[TB] FAIL bicubic_flat_acc: got %0d expected 12800", out_acc); else passed++;
    feed_group(0, 255, 255, 0, -9, 73, 73, -9);
    checks++; if (out_acc !== 20'sd37230) $display("[TB] FAIL bicubic_edge_acc: got %0d expected 37230", out_acc); else passed++;
    checks++; if (out_pixel !== 8'd255) $display("[TB] FAIL bicubic_edge_pixel: got %0d expected 255", out_pixel); else passed++;
    checks++; if (out_sat !== 1'b1) $display("[TB] FAIL bicubic_edge_sat: got %0b expected 1", out_sat); else passed++;
    tick();
  endtask

  task automatic test_most_negative;
    logic signed [19:0] exp_acc;
    exp_acc   = -20'sd65280;
    out_ready = 1'b1;
    feed_group(255, 0, 0, 0, -256, 0, 0, 0);
    checks++; if (out_acc !== exp_acc) $display("[TB] FAIL neg_acc: got %0d expected %0d", out_acc, exp_acc); else passed++;
    checks++; if (out_pixel !== 8'd0) $display("[TB] FAIL neg_pixel: got %0d expected 0", out_pixel); else passed++;
    checks++; if (out_sat !== 1'b1) $display("[TB] FAIL neg_sat: got %0b expected 1", out_sat); else passed++;
    tick();
  endtask

  task automatic test_rounding;
    out_ready = 1'b1;
    // 3*64 = 192 -> 1.5 rounds up to 2
    feed_group(3, 0, 0, 0, 64, 0, 0, 0);
    checks++; if (out_acc !== 20'sd192) $display("[TB] FAIL round_up_acc: got %0d expected 192", out_acc); else passed++;
    checks++; if (out_pixel !== 8'd2) $display("[TB] FAIL round_up_pixel: got %0d expected 2", out_pixel); else passed++;
    tick();
    // 3*63 = 189 -> 1.48 rounds down to 1
    feed_group(3, 0, 0, 0, 63, 0, 0, 0);
    checks++; if (out_pixel !== 8'd1) $display("[TB] FAIL round_down_pixel: got %0d expected 1", out_pixel); else passed++;
    checks++; if (out_sat !== 1'b0) $display("[TB] FAIL round_down_sat: got %0b expected 0", out_sat); else passed++;
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    feed_group(80, 0, 0, 0, 128, 0, 0, 0);
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_valid: got %0b expected 1", out_valid); else passed++;
    in_valid  = 1'b1;
    in_pixel  = 8'd9;
    in_weight = 9'sd128;
    #1;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %0b expected 0", in_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid: got %0b expected 1", out_valid); else passed++;
      checks++; if (out_pixel !== 8'd80) $display("[TB] FAIL bp_hold_pixel: got %0d expected 80", out_pixel); else passed++;
      checks++; if (out_acc !== 20'sd10240) $display("[TB] FAIL bp_hold_acc: got %0d expected 10240", out_acc); else passed++;
    end
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready_hold: got %0b expected 0", in_ready); else passed++;
  endtask

  // Entered with a result still pending and out_ready low.
  task automatic test_back_to_back;
    int grp_pix [3];
    int wts [4];
    int exp_pix;
    logic exp_valid;
    grp_pix[0] = 10;
    grp_pix[1] = 128;
    grp_pix[2] = 255;
    wts[0] = -9;
    wts[1] = 73;
    wts[2] = 73;
    wts[3] = -9;
    out_ready = 1'b1;
    for (int e = 0; e < 14; e++) begin
      if (e < 12) begin
        in_valid  = 1'b1;
        in_pixel  = 8'(grp_pix[e / 4]);
        in_weight = 9'(wts[e % 4]);
      end else begin
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_weight = '0;
      end
      tick();
      exp_valid = (e % 4 == 0) && (e >= 4) && (e <= 12);
      checks++; if (out_valid !== exp_valid) $display("[TB] FAIL b2b_valid_edge%0d: got %0b expected %0b", e, out_valid, exp_valid); else passed++;
      if (exp_valid) begin
        exp_pix = grp_pix[e / 4 - 1];
        checks++; if (out_pixel !== 8'(exp_pix)) $display("[TB] FAIL b2b_pixel_edge%0d: got %0d expected %0d", e, out_pixel, exp_pix); else passed++;
        checks++; if (out_sat !== 1'b0) $display("[TB] FAIL b2b_sat_edge%0d: got %0b expected 0", e, out_sat); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_group;
    out_ready = 1'b1;
    send_pair(50, 128);
    send_pair(99, 50);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_pixel  = 8'd33;
    in_weight = 9'sd100;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_after_reset: got %0b expected 0", out_valid); else passed++;
    send_pair(50, 128);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_pair1: got %0b expected 0", out_valid); else passed++;
    send_pair(0, 0);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_pair2: got %0b expected 0", out_valid); else passed++;
    send_pair(0, 0);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_pair3: got %0b expected 0", out_valid); else passed++;
    send_pair(0, 0);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_pair4: got %0b expected 0", out_valid); else passed++;
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL midrst_valid: got %0b expected 1", out_valid); else passed++;
    checks++; if (out_pixel !== 8'd50) $display("[TB] FAIL midrst_pixel: got %0d expected 50", out_pixel); else passed++;
    checks++; if (out_acc !== 20'sd6400) $display("[TB] FAIL midrst_acc: got %0d expected 6400", out_acc); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_single: got %0b expected 0", out_valid); else passed++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks    = 0;
    passed    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    in_weight = '0;
    out_ready = 1'b1;
    test_reset();
    test_identity();
    test_bicubic();
    test_most_negative();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
